// File: rtl/coin_acceptor.sv
// Coin-chute front end: synchronizes and debounces two sensors into exclusive one-cycle coin pulses.
// Optional input synchronizer is enabled by defining COIN_ACCEPTOR_SYNC_EN.
module coin_acceptor #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int HOLDOFF_CYCLES  = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic sense_5,
    input  logic sense_10,
    output logic coin_5,
    output logic coin_10,
    output logic coin_reject,
    output logic busy
);

    localparam int CNT_MAX = (DEBOUNCE_CYCLES > HOLDOFF_CYCLES) ? DEBOUNCE_CYCLES : HOLDOFF_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LAST = (HOLDOFF_CYCLES > 0) ? CW'(HOLDOFF_CYCLES - 1) : '0;

    typedef enum logic [1:0] {
        IDLE,
        DEBOUNCE,
        WAIT_RELEASE,
        HOLDOFF
    } state_t;

    // Sensor pair as seen by the FSM: bit 1 is the 10-unit sensor, bit 0 the 5-unit sensor.
    logic [1:0] p;

`ifdef COIN_ACCEPTOR_SYNC_EN
    logic [1:0] sync_1;
    logic [1:0] sync_2;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_1 <= '0;
            sync_2 <= '0;
        end else begin
            sync_1 <= {sense_10, sense_5};
            sync_2 <= sync_1;
        end
    end

    assign p = sync_2;
`else
    assign p = {sense_10, sense_5};
`endif

    state_t          state;
    state_t          state_next;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_next;
    logic [1:0]      pat;
    logic [1:0]      pat_next;
    logic            accept;
    logic [1:0]      accept_pat;

    // Reset parks in WAIT_RELEASE so a coin already in the chute must be released before counting.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= WAIT_RELEASE;
            cnt         <= '0;
            pat         <= '0;
            coin_5      <= 1'b0;
            coin_10     <= 1'b0;
            coin_reject <= 1'b0;
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            pat         <= pat_next;
            coin_5      <= accept && (accept_pat == 2'b01);
            coin_10     <= accept && (accept_pat == 2'b10);
            coin_reject <= accept && (accept_pat == 2'b11);
        end
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        pat_next   = pat;
        accept     = 1'b0;
        accept_pat = pat;

        unique case (state)
            IDLE: begin
                if (p != 2'b00) begin
                    pat_next = p;
                    if (DEBOUNCE_CYCLES == 1) begin
                        accept     = 1'b1;
                        accept_pat = p;
                        state_next = WAIT_RELEASE;
                        cnt_next   = '0;
                    end else begin
                        state_next = DEBOUNCE;
                        cnt_next   = CW'(1);
                    end
                end
            end

            DEBOUNCE: begin
                if (p != pat) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (cnt == DEB_LAST) begin
                    accept     = 1'b1;
                    state_next = WAIT_RELEASE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end

            WAIT_RELEASE: begin
                if (p != 2'b00) begin
                    cnt_next = '0;
                end else if (cnt == DEB_LAST) begin
                    cnt_next   = '0;
                    state_next = (HOLDOFF_CYCLES == 0) ? IDLE : HOLDOFF;
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end

            HOLDOFF: begin
                if (cnt == HOLD_LAST) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end

            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_coin_acceptor.sv
// Scoreboard bench for coin_acceptor: stimulus queues expected pulses, a monitor pops and compares.
module tb_coin_acceptor;

    localparam int D        = 4;
    localparam int H        = 2;
`ifdef COIN_ACCEPTOR_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif
    localparam int L_ACC    = D - 1 + SYNC_LAT;  // raw edge E0 to pulse-registering edge
    localparam int L_REL    = D + H - 1 + SYNC_LAT;  // first raw-low edge to IDLE edge
    localparam int MIN_GAP  = 2 * D + H;

    localparam int K5   = 1;
    localparam int K10  = 2;
    localparam int KREJ = 3;

    typedef struct {
        int kind;
        int cycle;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    logic sense_5 = 1'b0;
    logic sense_10 = 1'b0;
    logic coin_5;
    logic coin_10;
    logic coin_reject;
    logic busy;

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   last_pulse = -1;
    exp_t exp_q[$];

    coin_acceptor #(
        .DEBOUNCE_CYCLES(D),
        .HOLDOFF_CYCLES (H)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .sense_5    (sense_5),
        .sense_10   (sense_10),
        .coin_5     (coin_5),
        .coin_10    (coin_10),
        .coin_reject(coin_reject),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input bit ok, input string name, input int act, input int exp);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_exp(input int kind, input int cycle);
        exp_t e;
        e.kind  = kind;
        e.cycle = cycle;
        exp_q.push_back(e);
    endtask

    task automatic wait_until(input int target);
        int guard = 0;
        while (cyc < target && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        check(cyc == target, "reach_cycle", cyc, target);
    endtask

    task automatic check_busy_at(input int target, input logic exp, input string name);
        wait_until(target);
        check(busy == exp, name, int'(busy), int'(exp));
    endtask

    task automatic wait_idle(input string name);
        int guard = 0;
        while (busy !== 1'b0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check(busy == 1'b0, name, int'(busy), 0);
        repeat (5) @(negedge clk);
    endtask

    // Monitor: every cycle with any pulse high is matched against the head of the queue.
    always @(negedge clk) begin
        int   hi;
        int   kind;
        exp_t e;
        if (reset_n) begin
            hi = int'(coin_5) + int'(coin_10) + int'(coin_reject);
            if (hi != 0) begin
                kind = coin_5 ? K5 : (coin_10 ? K10 : KREJ);
                check(hi == 1, "pulse_onehot", hi, 1);
                check(exp_q.size() != 0, "pulse_expected", kind, 0);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check(kind == e.kind, "pulse_kind", kind, e.kind);
                    check(cyc == e.cycle, "pulse_cycle", cyc, e.cycle);
                end
                if (last_pulse >= 0)
                    check(cyc - last_pulse >= MIN_GAP, "pulse_spacing", cyc - last_pulse, MIN_GAP);
                last_pulse = cyc;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int e0;
        int er;
        int r1;

        // Reset state and release to IDLE.
        #1 reset_n = 1'b0;
        #2;
        check(busy == 1'b1, "reset_busy", int'(busy), 1);
        check({coin_5, coin_10, coin_reject} == 3'b000, "reset_pulses",
              int'({coin_5, coin_10, coin_reject}), 0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        r1 = cyc + 1;
        check_busy_at(r1 + D + H - 2, 1'b1, "reset_release_busy");
        check_busy_at(r1 + D + H - 1, 1'b0, "reset_release_idle");
        repeat (3) @(negedge clk);

        // Clean coin: 10 samples high.
        sense_5 = 1'b1;
        e0 = cyc + 1;
        push_exp(K5, e0 + L_ACC);
        repeat (10) @(negedge clk);
        sense_5 = 1'b0;
        er = cyc + 1;
        check_busy_at(er + L_REL - 1, 1'b1, "clean_busy_hold");
        check_busy_at(er + L_REL, 1'b0, "clean_busy_idle");
        repeat (5) @(negedge clk);

        // Bounce: 2 high, 1 low, 8 high; accepted from the second rise.
        sense_10 = 1'b1;
        e0 = cyc + 1;
        push_exp(K10, e0 + 3 + L_ACC);
        repeat (2) @(negedge clk);
        sense_10 = 1'b0;
        repeat (1) @(negedge clk);
        sense_10 = 1'b1;
        repeat (8) @(negedge clk);
        sense_10 = 1'b0;
        wait_idle("bounce_idle");

        // Glitch shorter than the debounce window.
        sense_5 = 1'b1;
        repeat (3) @(negedge clk);
        sense_5 = 1'b0;
        repeat (8) @(negedge clk);
        check(busy == 1'b0, "glitch_idle", int'(busy), 0);

        // Both sensors together.
        sense_5  = 1'b1;
        sense_10 = 1'b1;
        e0 = cyc + 1;
        push_exp(KREJ, e0 + L_ACC);
        repeat (6) @(negedge clk);
        sense_5  = 1'b0;
        sense_10 = 1'b0;
        wait_idle("reject_idle");

        // Back-to-back: second 6-cycle coin reaches IDLE with exactly D samples left.
        sense_5 = 1'b1;
        e0 = cyc + 1;
        push_exp(K5, e0 + L_ACC);
        push_exp(K5, e0 + 12 + L_ACC);
        repeat (6) @(negedge clk);
        sense_5 = 1'b0;
        repeat (4) @(negedge clk);
        sense_5 = 1'b1;
        repeat (6) @(negedge clk);
        sense_5 = 1'b0;
        wait_idle("b2b_idle");

        // Back-to-back: second 2-cycle coin lies wholly inside HOLDOFF and is dropped.
        sense_5 = 1'b1;
        e0 = cyc + 1;
        push_exp(K5, e0 + L_ACC);
        repeat (6) @(negedge clk);
        sense_5 = 1'b0;
        repeat (4) @(negedge clk);
        sense_5 = 1'b1;
        repeat (2) @(negedge clk);
        sense_5 = 1'b0;
        wait_idle("holdoff_drop_idle");

        // Coin held across reset is never counted.
        reset_n = 1'b0;
        sense_5 = 1'b1;
        #1;
        check(busy == 1'b1, "reset_held_busy", int'(busy), 1);
        check(coin_5 == 1'b0, "reset_held_coin5", int'(coin_5), 0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (20) @(negedge clk);
        sense_5 = 1'b0;
        er = cyc + 1;
        check_busy_at(er + L_REL - 1, 1'b1, "held_busy_hold");
        check_busy_at(er + L_REL, 1'b0, "held_busy_idle");
        repeat (5) @(negedge clk);

        // Reset mid-debounce aborts the candidate.
        sense_5 = 1'b1;
        e0 = cyc + 1;
        wait_until(e0 + L_ACC - 1);
        #1 reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        sense_5 = 1'b0;
        wait_idle("abort_idle");

        // Reset while the pulse is high clears it at once.
        sense_5 = 1'b1;
        e0 = cyc + 1;
        push_exp(K5, e0 + L_ACC);
        wait_until(e0 + L_ACC);
        #1;
        check(coin_5 == 1'b1, "pulse_before_reset", int'(coin_5), 1);
        reset_n = 1'b0;
        #1;
        check(coin_5 == 1'b0, "reset_clears_pulse", int'(coin_5), 0);
        @(negedge clk);
        reset_n = 1'b1;
        sense_5 = 1'b0;
        wait_idle("final_idle");

        repeat (10) @(negedge clk);
        check(exp_q.size() == 0, "pending_pulses", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
